sync_fifo_param: RTL and testbench
==================================

SYNC_FIFO_PARAM -- requirements
Module: sync_fifo_param

Interface
REQ-001 The block SHALL have parameter DEPTH, default 16, number of entries (power of 2, >= 4).
REQ-002 The block SHALL have parameter PTRWIDTH, default 4, log2(DEPTH).
REQ-003 The block SHALL have parameter DWIDTH, default 8, data width in bits.
REQ-004 The block SHALL have parameter AFULL_TH, default 12, almost-full threshold (1..DEPTH-1).
REQ-005 The block SHALL have parameter AEMPTY_TH, default 4, almost-empty threshold (1..DEPTH-1).
REQ-006 The block SHALL have parameter FWFT, default 0, read mode (0 = registered read, 1 = first-word-fall-through).
REQ-007 The block SHALL have port clk, input, 1, the single clock; all logic rising-edge.
REQ-008 The block SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-009 The block SHALL have port clr, input, 1, synchronous flush.
REQ-010 The block SHALL have port push, input, 1, write request.
REQ-011 The block SHALL have port wdata, input, DWIDTH, write data.
REQ-012 The block SHALL have port pop, input, 1, read request.
REQ-013 The block SHALL have port rdata, output, DWIDTH, read data.
REQ-014 The block SHALL have port full, output, 1, count == DEPTH.
REQ-015 The block SHALL have port empty, output, 1, count == 0.
REQ-016 The block SHALL have port almost_full, output, 1, count >= AFULL_TH.
REQ-017 The block SHALL have port almost_empty, output, 1, count <= AEMPTY_TH.
REQ-018 The block SHALL have port count, output, PTRWIDTH+1, current occupancy.
REQ-019 The block SHALL have port overflow, output, 1, sticky rejected-push flag.
REQ-020 The block SHALL have port underflow, output, 1, sticky rejected-pop flag.

Function
REQ-021 Storage SHALL be DEPTH x DWIDTH; write/read pointers PTRWIDTH bits, wrap DEPTH-1 -> 0.
REQ-022 A pop SHALL be accepted iff pop && !empty.
REQ-023 A push SHALL be accepted iff push && (!full || pop accepted same cycle); full with push+pop: write and read both occur, count unchanged.
REQ-024 Empty with push+pop: pop rejected, push accepted, count 0 -> 1.
REQ-025 Count SHALL update on the clock edge: +1 push only, -1 pop only, unchanged both/neither; never exceeds DEPTH or drops below 0.
REQ-026 full, empty, almost_full, almost_empty SHALL be registered and reflect count after the same edge (no extra lag).
REQ-027 FWFT=0: rdata SHALL register mem[rptr] on the edge a pop is accepted (1-cycle latency) and hold otherwise.
REQ-028 FWFT=1: rdata SHALL equal mem[rptr] whenever !empty, valid the cycle after the first write's edge; pop advances to the next entry; rdata don't-care while empty.
REQ-029 push && full && !pop SHALL set overflow; pop && empty SHALL set underflow; both remain set until reset or clr.
REQ-030 clr SHALL, on the next edge, zero pointers, count, overflow and underflow, set empty/almost_empty, and override push/pop in that cycle; memory contents need not be cleared.

Reset
REQ-031 reset high SHALL immediately, without clock: pointers 0, count 0, empty 1, almost_empty 1, full 0, almost_full 0, overflow 0, underflow 0, rdata 0.
REQ-032 reset asserted mid-operation SHALL discard all contents; first pop after release returns data pushed after release.
REQ-033 Operation SHALL resume on the first rising edge after reset deasserts.

Verification
REQ-034 Reset, push 0x01..0x10 (DEPTH=16) -> count 16, full 1, almost_full 1 from 12th push; 17th push -> rejected, overflow 1.
REQ-035 From full, 16 pops (FWFT=0) -> rdata 0x01..0x10 each one cycle after its pop, empty 1 after 16th; extra pop -> underflow 1, rdata holds 0x10.
REQ-036 Count 16, push 0xAA + pop same cycle -> count 16, full 1, overflow 0; 0xAA read last after wrap.
REQ-037 FWFT=1, push 0x55 into empty -> next cycle empty 0, rdata 0x55 with no pop; pop -> empty 1.
REQ-038 Count 8 with overflow 1, assert clr -> next edge count 0, empty 1, overflow 0; reset asynchronously mid-burst -> all outputs at reset values before next edge.

Source files
------------

// File: rtl/sync_fifo_param.sv
// Single-clock parameterised FIFO with registered status flags, sticky error flags,
// synchronous flush and a choice of registered or first-word-fall-through read data.
module sync_fifo_param #(
  parameter int DEPTH     = 16,
  parameter int PTRWIDTH  = 4,
  parameter int DWIDTH    = 8,
  parameter int AFULL_TH  = 12,
  parameter int AEMPTY_TH = 4,
  parameter int FWFT      = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clr,
  input  logic                push,
  input  logic [DWIDTH-1:0]   wdata,
  input  logic                pop,
  output logic [DWIDTH-1:0]   rdata,
  output logic                full,
  output logic                empty,
  output logic                almost_full,
  output logic                almost_empty,
  output logic [PTRWIDTH:0]   count,
  output logic                overflow,
  output logic                underflow
);

  localparam logic [PTRWIDTH:0]   DEPTH_C  = DEPTH[PTRWIDTH:0];
  localparam logic [PTRWIDTH:0]   AFULL_C  = AFULL_TH[PTRWIDTH:0];
  localparam logic [PTRWIDTH:0]   AEMPTY_C = AEMPTY_TH[PTRWIDTH:0];
  localparam logic [PTRWIDTH:0]   CNT_ONE  = {{PTRWIDTH{1'b0}}, 1'b1};
  localparam logic [PTRWIDTH-1:0] PTR_ONE  = {{(PTRWIDTH-1){1'b0}}, 1'b1};

  logic [DWIDTH-1:0]   mem [DEPTH];
  logic [PTRWIDTH-1:0] wptr, rptr;
  logic [PTRWIDTH:0]   count_nxt;
  logic                pop_ok, push_ok;

  // A pop frees a slot in the same cycle, so a full FIFO may take a push alongside it.
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  always_comb begin
    count_nxt = count;
    case ({push_ok, pop_ok})
      2'b10:   count_nxt = count + CNT_ONE;
      2'b01:   count_nxt = count - CNT_ONE;
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push_ok && !clr) begin
      mem[wptr] <= wdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr         <= '0;
      rptr         <= '0;
      count        <= '0;
      full         <= 1'b0;
      empty        <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else if (clr) begin
      wptr         <= '0;
      rptr         <= '0;
      count        <= '0;
      full         <= 1'b0;
      empty        <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      if (push_ok) wptr <= wptr + PTR_ONE;
      if (pop_ok)  rptr <= rptr + PTR_ONE;
      count        <= count_nxt;
      full         <= (count_nxt == DEPTH_C);
      empty        <= (count_nxt == '0);
      almost_full  <= (count_nxt >= AFULL_C);
      almost_empty <= (count_nxt <= AEMPTY_C);
      if (push && full && !pop) overflow  <= 1'b1;
      if (pop && empty)         underflow <= 1'b1;
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // Head entry is visible directly; forced to zero while empty so reset shows 0.
      assign rdata = empty ? '0 : mem[rptr];
    end else begin : g_reg
      logic [DWIDTH-1:0] rdata_q;
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          rdata_q <= '0;
        end else if (pop_ok && !clr) begin
          rdata_q <= mem[rptr];
        end
      end
      assign rdata = rdata_q;
    end
  endgenerate

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed bench for sync_fifo_param: one registered-read instance and one
// first-word-fall-through instance sharing clock, reset and flush.
module tb_sync_fifo_param;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       clr = 1'b0;
  logic       push = 1'b0, pop = 1'b0;
  logic [7:0] wdata = '0;
  logic [7:0] rdata;
  logic       full, empty, almost_full, almost_empty, overflow, underflow;
  logic [4:0] count;

  logic       push1 = 1'b0, pop1 = 1'b0;
  logic [7:0] wdata1 = '0;
  logic [7:0] rdata1;
  logic       full1, empty1, almost_full1, almost_empty1, overflow1, underflow1;
  logic [4:0] count1;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  sync_fifo_param #(.FWFT(0)) dut0 (
    .clk(clk), .reset(reset), .clr(clr), .push(push), .wdata(wdata), .pop(pop),
    .rdata(rdata), .full(full), .empty(empty), .almost_full(almost_full),
    .almost_empty(almost_empty), .count(count), .overflow(overflow), .underflow(underflow)
  );

  sync_fifo_param #(.FWFT(1)) dut1 (
    .clk(clk), .reset(reset), .clr(clr), .push(push1), .wdata(wdata1), .pop(pop1),
    .rdata(rdata1), .full(full1), .empty(empty1), .almost_full(almost_full1),
    .almost_empty(almost_empty1), .count(count1), .overflow(overflow1), .underflow(underflow1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " count"}, 32'(count), 32'd0);
    chk({tag, " empty"}, 32'(empty), 32'd1);
    chk({tag, " aempty"}, 32'(almost_empty), 32'd1);
    chk({tag, " full"}, 32'(full), 32'd0);
    chk({tag, " afull"}, 32'(almost_full), 32'd0);
    chk({tag, " ovf"}, 32'(overflow), 32'd0);
    chk({tag, " unf"}, 32'(underflow), 32'd0);
    chk({tag, " rdata"}, 32'(rdata), 32'd0);
  endtask

  task automatic fill16();
    for (int i = 1; i <= 16; i++) begin
      push = 1'b1; wdata = 8'(i);
      tick();
    end
    push = 1'b0;
  endtask

  initial begin
    // asynchronous reset, observed before the first clock edge
    #2 reset = 1'b1;
    #1 chk_reset_vals("por");
    tick(); tick();
    reset = 1'b0;
    tick();

    // fill with threshold boundaries
    for (int i = 1; i <= 16; i++) begin
      push = 1'b1; wdata = 8'(i);
      tick();
      chk($sformatf("fill count %0d", i), 32'(count), 32'(i));
      chk($sformatf("fill afull %0d", i), 32'(almost_full), 32'(i >= 12));
      chk($sformatf("fill aempty %0d", i), 32'(almost_empty), 32'(i <= 4));
      chk($sformatf("fill full %0d", i), 32'(full), 32'(i == 16));
    end
    wdata = 8'h11;
    tick();
    push = 1'b0;
    chk("push17 count", 32'(count), 32'd16);
    chk("push17 overflow", 32'(overflow), 32'd1);

    // drain in order, then one extra pop
    for (int i = 1; i <= 16; i++) begin
      pop = 1'b1;
      tick();
      chk($sformatf("drain rdata %0d", i), 32'(rdata), 32'(i));
      chk($sformatf("drain empty %0d", i), 32'(empty), 32'(i == 16));
    end
    tick();
    pop = 1'b0;
    chk("extra pop underflow", 32'(underflow), 32'd1);
    chk("extra pop rdata hold", 32'(rdata), 32'h10);
    chk("extra pop count", 32'(count), 32'd0);

    clr = 1'b1; tick(); clr = 1'b0;
    chk("clr1 ovf", 32'(overflow), 32'd0);
    chk("clr1 unf", 32'(underflow), 32'd0);

    // simultaneous push and pop while empty: only the push lands
    push = 1'b1; pop = 1'b1; wdata = 8'h33;
    tick();
    push = 1'b0; pop = 1'b0;
    chk("empty pp count", 32'(count), 32'd1);
    chk("empty pp unf", 32'(underflow), 32'd1);
    pop = 1'b1; tick(); pop = 1'b0;
    chk("empty pp rdata", 32'(rdata), 32'h33);
    clr = 1'b1; tick(); clr = 1'b0;

    // full with push and pop together; 0xAA comes out last after wrap
    fill16();
    push = 1'b1; pop = 1'b1; wdata = 8'hAA;
    tick();
    push = 1'b0; pop = 1'b0;
    chk("full pp count", 32'(count), 32'd16);
    chk("full pp full", 32'(full), 32'd1);
    chk("full pp ovf", 32'(overflow), 32'd0);
    chk("full pp rdata", 32'(rdata), 32'h01);
    for (int i = 0; i < 16; i++) begin
      pop = 1'b1;
      tick();
      chk($sformatf("wrap rdata %0d", i), 32'(rdata), (i < 15) ? 32'(i + 2) : 32'hAA);
    end
    pop = 1'b0;
    chk("wrap empty", 32'(empty), 32'd1);

    // flush from count 8 with overflow set
    fill16();
    push = 1'b1; wdata = 8'hEE; tick(); push = 1'b0;
    for (int i = 0; i < 8; i++) begin
      pop = 1'b1; tick();
    end
    pop = 1'b0;
    chk("pre clr count", 32'(count), 32'd8);
    chk("pre clr ovf", 32'(overflow), 32'd1);
    clr = 1'b1; push = 1'b1; wdata = 8'h99; tick(); clr = 1'b0; push = 1'b0;
    chk("clr count", 32'(count), 32'd0);
    chk("clr empty", 32'(empty), 32'd1);
    chk("clr aempty", 32'(almost_empty), 32'd1);
    chk("clr ovf", 32'(overflow), 32'd0);

    // first-word-fall-through instance
    push1 = 1'b1; wdata1 = 8'h55; tick(); push1 = 1'b0;
    chk("fwft empty", 32'(empty1), 32'd0);
    chk("fwft rdata", 32'(rdata1), 32'h55);
    push1 = 1'b1; wdata1 = 8'h66; tick(); push1 = 1'b0;
    chk("fwft head held", 32'(rdata1), 32'h55);
    pop1 = 1'b1; tick();
    chk("fwft next", 32'(rdata1), 32'h66);
    tick(); pop1 = 1'b0;
    chk("fwft drained", 32'(empty1), 32'd1);

    // asynchronous reset mid-burst
    for (int i = 0; i < 5; i++) begin
      push = 1'b1; wdata = 8'(8'hC0 + i); tick();
    end
    pop = 1'b1; tick();
    push = 1'b0; pop = 1'b0;
    #2 reset = 1'b1;
    #1 chk_reset_vals("mid");
    tick();
    reset = 1'b0;
    push = 1'b1; wdata = 8'h77; tick(); push = 1'b0;
    chk("post reset count", 32'(count), 32'd1);
    pop = 1'b1; tick(); pop = 1'b0;
    chk("post reset rdata", 32'(rdata), 32'h77);
    chk("post reset empty", 32'(empty), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
